// File: rtl/div3_serial_if.sv
// div3_serial_if
//   Handshake bundle for the serial divide-by-3 unit.
//   Producer side: in_valid/in_ready/in.
//   Consumer side: out_valid/out_ready/quotient/remainder/divisible.
//   Modports:
//     master -- the environment (drives operands, accepts results)
//     slave  -- the divider itself
interface div3_serial_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [1:0]       remainder;
    logic             divisible;

    modport master (
        output in_valid, in, out_ready,
        input  in_ready, out_valid, quotient, remainder, divisible
    );

    modport slave (
        input  in_valid, in, out_ready,
        output in_ready, out_valid, quotient, remainder, divisible
    );
endinterface

// File: rtl/div3_serial.sv
// div3_serial
//   Sequential divide-by-3. An accepted WIDTH-bit unsigned operand is walked
//   MSB-first through a 3-state remainder recurrence, one bit per clock,
//   rebuilding quotient and remainder so that n = 3*quotient + remainder.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high reset (aborts any operation in flight)
//     bus    div3_serial_if.slave:
//              in_valid/in_ready/in                      operand handshake
//              out_valid/out_ready                       result handshake
//              quotient/remainder/divisible              result, held until the
//                                                        next result is produced
module div3_serial #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    div3_serial_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] pq;
    logic [1:0]       rem;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] quo_reg;
    logic [1:0]       rem_reg;
    logic             div_reg;

    logic             qbit;
    logic [1:0]       rem_next;
    logic [WIDTH-1:0] pq_next;
    logic             last_bit;

    // One step of long division by 3: t = 2*r + b is at most 5, so a single
    // conditional subtract keeps the running remainder in 0..2.
    // Returns {qbit, r_next}.
    function automatic logic [2:0] div_step(input logic [1:0] r, input logic b);
        logic [2:0] t;
        t = {r, b};
        if (t >= 3'd3) begin
            div_step = {1'b1, 2'(t - 3'd3)};
        end else begin
            div_step = {1'b0, t[1:0]};
        end
    endfunction

    always_comb begin
        {qbit, rem_next} = div_step(rem, shreg[WIDTH-1]);
        pq_next          = (pq << 1) | WIDTH'(qbit);
        last_bit         = (cnt == CNT_W'(1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = SHIFT;
            SHIFT:   if (last_bit)     state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand load, bit-serial recurrence, result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg   <= '0;
            pq      <= '0;
            rem     <= '0;
            cnt     <= '0;
            quo_reg <= '0;
            rem_reg <= '0;
            div_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        shreg <= bus.in;
                        pq    <= '0;
                        rem   <= '0;
                        cnt   <= CNT_W'(WIDTH);
                    end
                end
                SHIFT: begin
                    shreg <= shreg << 1;
                    pq    <= pq_next;
                    rem   <= rem_next;
                    cnt   <= cnt - CNT_W'(1);
                    // Capture straight from the step outputs so the result is
                    // valid on the same edge that consumes the last bit.
                    if (last_bit) begin
                        quo_reg <= pq_next;
                        rem_reg <= rem_next;
                        div_reg <= (rem_next == 2'd0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.quotient  = quo_reg;
    assign bus.remainder = rem_reg;
    assign bus.divisible = div_reg;

endmodule

// File: tb/tb_div3_serial.sv
// tb_div3_serial
//   Directed and randomized bench for div3_serial. Expected results come from
//   plain integer division (n/3, n%3) and a queue of accepted operands.
module tb_div3_serial;

    localparam int WIDTH = 8;

    logic clk;
    logic reset;

    int n_tests = 0;
    int n_fail  = 0;

    div3_serial_if #(.WIDTH(WIDTH)) bus ();

    div3_serial #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic accept(input int n);
        bus.in       = WIDTH'(n);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input int n);
        chk({tag, "_q"}, bus.quotient,  n / 3);
        chk({tag, "_r"}, bus.remainder, n % 3);
        chk({tag, "_d"}, bus.divisible, (n % 3) == 0);
    endtask

    // Full operation: accept n, check latency and result, hold the result for
    // 'stall' cycles (optionally pulsing in_valid with in=7), then hand it off.
    task automatic op(input int n, input int stall, input logic pulse_busy);
        int lat;
        bus.out_ready = (stall == 0);
        chk("idle_in_ready", bus.in_ready, 1);
        accept(n);
        chk("busy_in_ready", bus.in_ready, 0);
        chk("busy_out_valid", bus.out_valid, 0);
        wait_result(lat);
        chk("latency", lat, WIDTH);
        check_result("res", n);
        for (int i = 0; i < stall; i++) begin
            if (pulse_busy) begin
                bus.in       = 8'd7;
                bus.in_valid = (i % 2) == 0;
            end
            @(negedge clk);
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_in_ready", bus.in_ready, 0);
            check_result("hold", n);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("post_out_valid", bus.out_valid, 0);
        chk("post_in_ready", bus.in_ready, 1);
        chk("post_keep_q", bus.quotient, n / 3);
    endtask

    initial begin
        int lat;
        int saw;
        int exp_q[$];
        int next_n;
        int got;
        int cycles;
        int n;
        int ops[5];

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in        = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_q", bus.quotient, 0);
        chk("rst_r", bus.remainder, 0);
        chk("rst_d", bus.divisible, 0);

        // Zero operand, result visible for exactly one cycle
        op(0, 0, 1'b0);

        // Operand sweep
        ops = '{7, 45, 100, 254, 255};
        foreach (ops[i]) op(ops[i], 0, 1'b0);

        // Backpressure with ignored in_valid pulses
        op(96, 5, 1'b1);

        // Input changes while busy
        bus.out_ready = 1'b1;
        accept(100);
        bus.in       = 8'd0;
        bus.in_valid = 1'b1;
        wait_result(lat);
        chk("busy_chg_latency", lat, WIDTH);
        check_result("busy_chg", 100);
        @(negedge clk);
        chk("busy_chg_in_ready", bus.in_ready, 1);
        chk("busy_chg_out_valid", bus.out_valid, 0);
        @(negedge clk);
        chk("busy_chg_accept0", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        wait_result(lat);
        chk("second_latency", lat, WIDTH);
        check_result("second", 0);
        @(negedge clk);
        chk("second_post_valid", bus.out_valid, 0);

        // Reset in the middle of SHIFT
        accept(255);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_q", bus.quotient, 0);
        chk("abort_r", bus.remainder, 0);
        chk("abort_d", bus.divisible, 0);
        saw = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) saw = 1;
        end
        chk("abort_no_result", saw, 0);
        op(6, 0, 1'b0);

        // All operands back-to-back with random consumer stalls
        next_n = 0;
        got    = 0;
        cycles = 0;
        while (got < 256 && cycles < 20000) begin
            bus.out_ready = ($urandom_range(0, 2) != 0);
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_result", 1, 0);
                end else begin
                    n = exp_q.pop_front();
                    chk("ex_identity", 3 * bus.quotient + bus.remainder, n);
                    chk("ex_r_range", bus.remainder < 2'd3, 1);
                    chk("ex_q", bus.quotient, n / 3);
                    chk("ex_d", bus.divisible, (n % 3) == 0);
                end
                got++;
            end
            bus.in_valid = (next_n < 256);
            bus.in       = WIDTH'(next_n);
            if (bus.in_valid && bus.in_ready === 1'b1) begin
                exp_q.push_back(next_n);
                next_n++;
            end
            @(negedge clk);
            cycles++;
        end
        bus.in_valid = 1'b0;
        chk("ex_all_results", got, 256);
        chk("ex_all_accepted", next_n, 256);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
